bpsk_demod: RTL and testbench

BPSK_DEMOD -- requirements
Module: bpsk_demod

---
 rtl/bpsk_demod.sv | 144 ++++++++++++++
 tb/tb_bpsk_demod.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bpsk_demod.sv
// BPSK integrate-and-dump demodulator: one signed accumulate per bit period, sign decision,
// single-entry output holding register. Optional squelch: define BPSK_DEMOD_SQUELCH_EN.
module bpsk_demod #(
  parameter int SPB    = 16,
  parameter int THRESH = 2048
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic        sValid,
  input  logic [15:0] dIn,
  input  logic        wFull,
  output logic        wEN,
  output logic        dOut,
  output logic        ovf,
  output logic [7:0]  eraseCnt
);

  // state | meaning
  // IDLE  | no sample accepted since reset or since en dropped
  // ACC   | integrating samples of the current symbol
  // EMPTY | output register holds nothing to deliver
  // PEND  | output register holds a bit waiting for the FIFO
  localparam logic IDLE  = 1'b0;
  localparam logic ACC   = 1'b1;
  localparam logic EMPTY = 1'b0;
  localparam logic PEND  = 1'b1;

  localparam int KW = $clog2(SPB);
  localparam int AW = 17 + KW;
  localparam logic [KW-1:0] K_HALF = KW'(SPB / 2);
  localparam logic [KW-1:0] K_LAST = KW'(SPB - 1);

  logic                 in_q, in_d;
  logic                 out_q, out_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 bit_q, bit_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic                 decide;
  logic                 load;
  logic                 emit;
  logic                 bit_new;
  logic signed [AW-1:0] samp_ext;
  logic signed [AW-1:0] sum_now;

  assign accept   = sValid & en;
  assign samp_ext = {{(AW-16){dIn[15]}}, dIn};
  // First half of the bit period correlates with +carrier, second half with -carrier.
  assign sum_now  = (k_q < K_HALF) ? (acc_q + samp_ext) : (acc_q - samp_ext);
  assign decide   = accept && (k_q == K_LAST);
  assign bit_new  = ~sum_now[AW-1];
  assign emit     = (out_q == PEND) && !wFull;

`ifdef BPSK_DEMOD_SQUELCH_EN
  localparam logic [31:0] THRESH_U = 32'(THRESH);

  logic [AW-1:0] sum_mag;
  logic          erase;
  logic [7:0]    era_q, era_d;

  assign sum_mag = sum_now[AW-1] ? AW'(-sum_now) : AW'(sum_now);
  assign erase   = ({{(32-AW){1'b0}}, sum_mag} < THRESH_U);
  assign load    = decide && !erase;

  always_comb begin
    era_d = era_q;
    if (decide && erase && (era_q != 8'hFF)) era_d = era_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) era_q <= 8'd0;
    else      era_q <= era_d;
  end

  assign eraseCnt = era_q;
`else
  assign load     = decide;
  assign eraseCnt = 8'd0;
`endif

  always_comb begin
    in_d  = in_q;
    k_d   = k_q;
    acc_d = acc_q;
    case (in_q)
      IDLE:    if (accept) in_d = ACC;
      default: if (!en)    in_d = IDLE;
    endcase
    if (!en) begin
      k_d   = '0;
      acc_d = '0;
    end else if (accept) begin
      if (k_q == K_LAST) begin
        k_d   = '0;
        acc_d = '0;
      end else begin
        k_d   = k_q + KW'(1);
        acc_d = sum_now;
      end
    end
  end

  // A decision may replace the held bit only on the edge that delivers it.
  always_comb begin
    out_d = out_q;
    bit_d = bit_q;
    ovf_d = ovf_q;
    if (emit) out_d = EMPTY;
    if (load) begin
      if ((out_q == EMPTY) || emit) begin
        bit_d = bit_new;
        out_d = PEND;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      in_q  <= IDLE;
      out_q <= EMPTY;
      k_q   <= '0;
      acc_q <= '0;
      bit_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      in_q  <= in_d;
      out_q <= out_d;
      k_q   <= k_d;
      acc_q <= acc_d;
      bit_q <= bit_d;
      ovf_q <= ovf_d;
    end
  end

  assign wEN  = emit;
  assign dOut = bit_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bpsk_demod.sv
// Directed bench for bpsk_demod (SPB=16, THRESH=2048); expectations are hand-derived.
// Define BPSK_DEMOD_SQUELCH_EN for both bench and RTL to check the squelch build.
module tb_bpsk_demod;

  logic        CLK = 1'b0;
  logic        RST;
  logic        en;
  logic        sValid;
  logic [15:0] dIn;
  logic        wFull;
  logic        wEN;
  logic        dOut;
  logic        ovf;
  logic [7:0]  eraseCnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n0;
  logic pulse_bits[$];
  int   pulse_cyc[$];

  bpsk_demod #(.SPB(16), .THRESH(2048)) dut (
    .CLK(CLK), .RST(RST), .en(en), .sValid(sValid), .dIn(dIn), .wFull(wFull),
    .wEN(wEN), .dOut(dOut), .ovf(ovf), .eraseCnt(eraseCnt)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RST && wEN) begin
      pulse_bits.push_back(dOut);
      pulse_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Samples with index < 8 carry value a, the rest value b; indices first..first+count-1.
  task automatic send_samples(input int a, input int b, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      dIn    = (i < 8) ? 16'(a) : 16'(b);
      sValid = 1'b1;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle(input int n);
    sValid = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int exp_pulses;
    int exp_era;
    RST = 1'b0; en = 1'b0; sValid = 1'b0; dIn = '0; wFull = 1'b0;
    #23;
    chk("reset_wen", wEN, 0);
    chk("reset_dout", dOut, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_erase", eraseCnt, 0);
    @(negedge CLK); RST = 1'b1; en = 1'b1;
    idle(3);
    chk("post_reset_wen", wEN, 0);

    // +1000/-1000: sum 16000, bit 1 on the cycle after the 16th sample
    n0 = pulse_bits.size();
    send_samples(1000, -1000, 0, 16);
    chk("sym1_wen", wEN, 1);
    chk("sym1_dout", dOut, 1);
    idle(3);
    chk("sym1_pulses", pulse_bits.size() - n0, 1);

    // full-scale extremes: sum -524280, must not wrap
    n0 = pulse_bits.size();
    send_samples(-32768, 32767, 0, 16);
    chk("ext_wen", wEN, 1);
    chk("ext_dout", dOut, 0);
    idle(3);
    chk("ext_pulses", pulse_bits.size() - n0, 1);

    // FIFO full across two symbols: first held, second dropped
    n0 = pulse_bits.size();
    wFull = 1'b1;
    send_samples(1000, -1000, 0, 16);
    chk("full_hold_wen", wEN, 0);
    chk("full_hold_ovf", ovf, 0);
    send_samples(-1000, 1000, 0, 16);
    chk("full_drop_wen", wEN, 0);
    chk("full_drop_ovf", ovf, 1);
    wFull = 1'b0;
    idle(4);
    chk("full_pulses", pulse_bits.size() - n0, 1);
    if (pulse_bits.size() > n0) chk("full_bit", pulse_bits[n0], 1);
    chk("full_ovf_sticky", ovf, 1);

    // reset after 7 samples; next symbol counts from k=0
    send_samples(1000, -1000, 0, 7);
    sValid = 1'b0;
    RST = 1'b0;
    #2;
    chk("midrst_ovf", ovf, 0);
    chk("midrst_wen", wEN, 0);
    @(negedge CLK); RST = 1'b1;
    idle(2);
    n0 = pulse_bits.size();
    send_samples(-1000, 1000, 0, 15);
    chk("midrst_early_wen", wEN, 0);
    chk("midrst_early_pulses", pulse_bits.size() - n0, 0);
    send_samples(-1000, 1000, 15, 1);
    chk("midrst_wen", wEN, 1);
    chk("midrst_dout", dOut, 0);
    idle(3);

    // decision on the same edge as an emit: new bit loaded, ovf unchanged
    n0 = pulse_bits.size();
    wFull = 1'b1;
    send_samples(1000, -1000, 0, 16);
    send_samples(-1000, 1000, 0, 15);
    wFull = 1'b0;
    send_samples(-1000, 1000, 15, 1);
    chk("same_edge_wen", wEN, 1);
    chk("same_edge_dout", dOut, 0);
    chk("same_edge_ovf", ovf, 0);
    idle(3);
    chk("same_edge_pulses", pulse_bits.size() - n0, 2);
    if (pulse_bits.size() >= n0 + 2) begin
      chk("same_edge_bit0", pulse_bits[n0], 1);
      chk("same_edge_bit1", pulse_bits[n0+1], 0);
    end

    // en drop discards a partial symbol
    send_samples(1000, -1000, 0, 5);
    en = 1'b0;
    @(posedge CLK); #1;
    en = 1'b1;
    n0 = pulse_bits.size();
    send_samples(-1000, 1000, 0, 15);
    chk("en_early_pulses", pulse_bits.size() - n0, 0);
    chk("en_early_wen", wEN, 0);
    send_samples(-1000, 1000, 15, 1);
    chk("en_wen", wEN, 1);
    chk("en_dout", dOut, 0);
    idle(3);

    // weak symbol, sum 1600 < THRESH
`ifdef BPSK_DEMOD_SQUELCH_EN
    exp_pulses = 0; exp_era = 1;
`else
    exp_pulses = 1; exp_era = 0;
`endif
    n0 = pulse_bits.size();
    send_samples(100, -100, 0, 16);
    chk("weak_wen", wEN, 32'(exp_pulses));
    chk("weak_erase", eraseCnt, 32'(exp_era));
    idle(3);
    chk("weak_pulses", pulse_bits.size() - n0, 32'(exp_pulses));
    if (exp_pulses == 1 && pulse_bits.size() > n0) chk("weak_bit", pulse_bits[n0], 1);

    // back-to-back 1,0,1 with no sample gap
    n0 = pulse_bits.size();
    send_samples(1000, -1000, 0, 16);
    send_samples(-1000, 1000, 0, 16);
    send_samples(1000, -1000, 0, 16);
    idle(3);
    chk("b2b_pulses", pulse_bits.size() - n0, 3);
    if (pulse_bits.size() >= n0 + 3) begin
      chk("b2b_bit0", pulse_bits[n0], 1);
      chk("b2b_bit1", pulse_bits[n0+1], 0);
      chk("b2b_bit2", pulse_bits[n0+2], 1);
      chk("b2b_gap0", pulse_cyc[n0+1] - pulse_cyc[n0], 16);
      chk("b2b_gap1", pulse_cyc[n0+2] - pulse_cyc[n0+1], 16);
    end
    chk("final_ovf", ovf, 0);
    chk("final_erase", eraseCnt, 32'(exp_era));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
